// File: rtl/any1_bitfield_pipe.sv
// any1_bitfield_pipe: two-stage bitfield execution unit for the ANY-1 integer
// datapath. S1 captures the operands and the clamped field mask; S2 computes
// and holds the result. Valid/ready on both sides with full backpressure.
module any1_bitfield_pipe #(
  parameter int DWIDTH = 64,
  parameter int TAGW   = 6,
  localparam int PW    = $clog2(DWIDTH)
) (
  input  logic              rst_i,
  input  logic              clk_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        op_i,
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  input  logic [DWIDTH-1:0] c_i,
  input  logic [DWIDTH-1:0] d_i,
  input  logic [TAGW-1:0]   tag_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic [DWIDTH-1:0] mask_o,
  output logic [TAGW-1:0]   tag_o
);

  localparam logic [3:0] OP_SET  = 4'd0;
  localparam logic [3:0] OP_CLR  = 4'd1;
  localparam logic [3:0] OP_CHG  = 4'd2;
  localparam logic [3:0] OP_INS  = 4'd3;
  localparam logic [3:0] OP_EXT  = 4'd4;
  localparam logic [3:0] OP_EXTU = 4'd5;
  localparam logic [3:0] OP_FFO  = 4'd6;
  localparam logic [3:0] OP_CNT  = 4'd7;

  // Bits mb..min(mb+mw, DWIDTH-1). The end index is formed one bit wider so
  // that a field running past the MSB saturates instead of wrapping.
  function automatic logic [DWIDTH-1:0] field_mask(input logic [PW-1:0] mb,
                                                   input logic [PW-1:0] mw);
    logic [PW:0]       me;
    logic [DWIDTH-1:0] lo;
    logic [DWIDTH-1:0] hi;
    me = {1'b0, mb} + {1'b0, mw};
    lo = {DWIDTH{1'b1}} << mb;
    // ~me equals DWIDTH-1-me because DWIDTH-1 is all ones in PW bits
    hi = me[PW] ? {DWIDTH{1'b1}} : ({DWIDTH{1'b1}} >> (~me[PW-1:0]));
    return lo & hi;
  endfunction

  logic              s2_load;
  logic              accept;
  logic [PW-1:0]     mb_in;
  logic [PW-1:0]     mw_in;

  logic              s1_valid_q;
  logic [3:0]        s1_op_q;
  logic [DWIDTH-1:0] s1_a_q;
  logic [DWIDTH-1:0] s1_b_q;
  logic [DWIDTH-1:0] s1_mask_q;
  logic [PW-1:0]     s1_mb_q;
  logic [PW-1:0]     s1_mw_q;
  logic [TAGW-1:0]   s1_tag_q;

  logic              res_valid_q;
  logic [DWIDTH-1:0] res_q;
  logic [DWIDTH-1:0] mask_q;
  logic [TAGW-1:0]   tag_q;
  logic [DWIDTH-1:0] res_d;
  logic [DWIDTH-1:0] mask_d;

  logic [2*DWIDTH-1:0] funnel;
  logic [DWIDTH-1:0]   t;
  logic [DWIDTH-1:0]   keep;
  logic [DWIDTH-1:0]   am;
  logic [PW-1:0]       ffo_idx;
  logic                ffo_hit;
  logic [PW:0]         cnt;

  // Only the low PW bits of the offset/width operands are meaningful.
  logic unused_hi;
  assign unused_hi = ^{c_i[DWIDTH-1:PW], d_i[DWIDTH-1:PW]};

  assign mb_in       = c_i[PW-1:0];
  assign mw_in       = d_i[PW-1:0];
  assign s2_load     = !res_valid_q | res_ready_i;
  assign req_ready_o = !s1_valid_q | s2_load;
  assign accept      = req_valid_i & req_ready_o;

  // S1 occupancy: refilled (or emptied) whenever it can move on
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
    end else if (req_ready_o) begin
      s1_valid_q <= req_valid_i;
    end
  end

  // S1 payload, captured only when a request is accepted
  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_op_q   <= op_i;
      s1_a_q    <= a_i;
      s1_b_q    <= b_i;
      s1_mb_q   <= mb_in;
      s1_mw_q   <= mw_in;
      s1_tag_q  <= tag_i;
      s1_mask_q <= field_mask(mb_in, mw_in);
    end
  end

  // S1 -> S2 datapath: per-op result from the registered operands and mask
  always_comb begin
    funnel  = {s1_b_q, s1_a_q} >> s1_mb_q;
    t       = funnel[DWIDTH-1:0];
    keep    = {DWIDTH{1'b1}} >> (~s1_mw_q);
    am      = s1_a_q & s1_mask_q;
    ffo_idx = '0;
    ffo_hit = 1'b0;
    cnt     = '0;
    for (int n = 0; n < DWIDTH; n++) begin
      if (am[n]) begin
        ffo_idx = PW'(n);
        ffo_hit = 1'b1;
        cnt     = cnt + (PW+1)'(1);
      end
    end
    res_d  = '0;
    mask_d = s1_mask_q;
    case (s1_op_q)
      OP_SET:  res_d = s1_a_q | s1_mask_q;
      OP_CLR:  res_d = s1_a_q & ~s1_mask_q;
      OP_CHG:  res_d = s1_a_q ^ s1_mask_q;
      OP_INS:  res_d = (s1_a_q & ~s1_mask_q) | ((s1_b_q << s1_mb_q) & s1_mask_q);
      OP_EXTU: res_d = t & keep;
      OP_EXT:  res_d = (t & keep) | ({DWIDTH{t[s1_mw_q]}} & ~keep);
      OP_FFO:  res_d = ffo_hit ? DWIDTH'(ffo_idx - s1_mb_q) : {DWIDTH{1'b1}};
      OP_CNT:  res_d = DWIDTH'(cnt);
      default: begin
        res_d  = '0;
        mask_d = '0;
      end
    endcase
  end

  // S2 output register: loads when empty or being drained, holds otherwise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
      mask_q      <= '0;
      tag_q       <= '0;
    end else if (s2_load) begin
      res_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q  <= res_d;
        mask_q <= mask_d;
        tag_q  <= s1_tag_q;
      end
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;
  assign mask_o      = mask_q;
  assign tag_o       = tag_q;

endmodule

// File: tb/tb_any1_bitfield_pipe.sv
// tb_any1_bitfield_pipe: scoreboard bench for any1_bitfield_pipe (DWIDTH=64).
module tb_any1_bitfield_pipe;

  typedef struct {
    logic [63:0] res;
    logic [63:0] mask;
    logic [5:0]  tag;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  op_i;
  logic [63:0] a_i, b_i, c_i, d_i;
  logic [5:0]  tag_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [63:0] res_o, mask_o;
  logic [5:0]  tag_o;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   rnd_bp   = 1'b0;
  bit   ready_cmd = 1'b1;

  any1_bitfield_pipe #(.DWIDTH(64), .TAGW(6)) dut (
    .rst_i(rst_i), .clk_i(clk),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i), .tag_i(tag_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .mask_o(mask_o), .tag_o(tag_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent bit-level reference of the unit.
  function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                input int mb, input int mw,
                                output logic [63:0] r, output logic [63:0] m);
    int top;
    int cnt;
    logic [63:0] t;
    top = mb + mw;
    if (top > 63) top = 63;
    cnt = 0;
    for (int n = 0; n < 64; n++) begin
      m[n] = (n >= mb) && (n <= top);
      t[n] = (mb + n < 64) ? a[mb + n] : b[mb + n - 64];
    end
    r = '0;
    case (op)
      4'd0: for (int n = 0; n < 64; n++) r[n] = m[n] ? 1'b1 : a[n];
      4'd1: for (int n = 0; n < 64; n++) r[n] = m[n] ? 1'b0 : a[n];
      4'd2: for (int n = 0; n < 64; n++) r[n] = m[n] ? ~a[n] : a[n];
      4'd3: for (int n = 0; n < 64; n++) r[n] = m[n] ? b[n - mb] : a[n];
      4'd4: for (int n = 0; n < 64; n++) r[n] = (n <= mw) ? t[n] : t[mw];
      4'd5: for (int n = 0; n < 64; n++) r[n] = (n <= mw) ? t[n] : 1'b0;
      4'd6: begin
        r = '1;
        for (int n = 0; n < 64; n++) if (a[n] && m[n]) r = 64'(n - mb);
      end
      4'd7: begin
        for (int n = 0; n < 64; n++) if (a[n] && m[n]) cnt++;
        r = 64'(cnt);
      end
      default: begin
        r = '0;
        m = '0;
      end
    endcase
  endfunction

  // Sole writer of res_ready_i: commanded level or random backpressure.
  initial begin
    res_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      res_ready_i = rnd_bp ? 1'($urandom_range(0, 1)) : ready_cmd;
    end
  end

  // Output monitor: hold-stability while stalled, in-order scoreboard compare.
  initial begin
    bit          stalled;
    logic [63:0] h_res, h_mask;
    logic [5:0]  h_tag;
    exp_t        e;
    stalled = 1'b0;
    h_res = '0; h_mask = '0; h_tag = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", 64'(res_valid_o), 64'd1);
          chk("hold_res", res_o, h_res);
          chk("hold_mask", mask_o, h_mask);
          chk("hold_tag", 64'(tag_o), 64'(h_tag));
        end
        if (res_valid_o && res_ready_i) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 64'(res_valid_o), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("res", res_o, e.res);
            chk("mask", mask_o, e.mask);
            chk("tag", 64'(tag_o), 64'(e.tag));
          end
        end
        stalled = res_valid_o && !res_ready_i;
        h_res = res_o; h_mask = mask_o; h_tag = tag_o;
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int mb, input int mw, input logic [5:0] tag);
    req_valid_i = 1'b1;
    op_i  = op;
    a_i   = a;
    b_i   = b;
    c_i   = {$urandom, $urandom};
    c_i[5:0] = 6'(mb);
    d_i   = {$urandom, $urandom};
    d_i[5:0] = 6'(mw);
    tag_i = tag;
  endtask

  // Waits for the currently driven request to be taken, then records it.
  task automatic wait_accept(input logic [63:0] er, input logic [63:0] em, input logic [5:0] tag);
    bit acc;
    exp_t e;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready_o;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      e.res = er; e.mask = em; e.tag = tag;
      sb.push_back(e);
    end else begin
      chk("accept_timeout", 64'(acc), 64'd1);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input int mb, input int mw, input logic [5:0] tag,
                      input logic [63:0] er, input logic [63:0] em);
    drive(op, a, b, mb, mw, tag);
    wait_accept(er, em, tag);
  endtask

  task automatic send_m(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int mb, input int mw, input logic [5:0] tag);
    logic [63:0] r, m;
    model(op, a, b, mb, mw, r, m);
    send(op, a, b, mb, mw, tag, r, m);
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r, m;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0; c_i = '0; d_i = '0; tag_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(res_valid_o), 64'd0);
    chk("rst_res", res_o, 64'd0);
    chk("rst_mask", mask_o, 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    @(posedge clk);
    #3 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    #1;

    // Basic SET with latency check
    send(4'd0, 64'h0, 64'h0, 4, 3, 6'd5, 64'hF0, 64'hF0);
    idle();
    @(negedge clk);
    chk("lat1_valid", 64'(res_valid_o), 64'd0);
    @(negedge clk);
    chk("lat2_valid", 64'(res_valid_o), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors, back-to-back
    send(4'd3, 64'hFFFFFFFFFFFFFFFF, 64'h5, 8, 3, 6'd10, 64'hFFFFFFFFFFFFF5FF, 64'hF00);
    send(4'd5, 64'hF00, 64'h0, 8, 3, 6'd11, 64'hF, 64'hF00);
    send(4'd4, 64'hF00, 64'h0, 8, 3, 6'd12, 64'hFFFFFFFFFFFFFFFF, 64'hF00);
    send(4'd5, 64'h0, 64'h1, 4, 63, 6'd13, 64'h1000000000000000, 64'hFFFFFFFFFFFFFFF0);
    send(4'd0, 64'h0, 64'h0, 60, 10, 6'd14, 64'hF000000000000000, 64'hF000000000000000);
    send(4'd7, 64'hFF00, 64'h0, 4, 11, 6'd15, 64'h8, 64'hFFF0);
    send(4'd6, 64'h10000, 64'h0, 8, 15, 6'd16, 64'h8, 64'hFFFF00);
    send(4'd6, 64'h10000, 64'h0, 0, 7, 6'd17, 64'hFFFFFFFFFFFFFFFF, 64'hFF);
    send(4'd9, 64'h1234, 64'h5678, 3, 5, 6'd18, 64'h0, 64'h0);
    idle();
    drain();

    // Backpressure: output stalled, two accepts then ready drops
    @(posedge clk);
    #1 ready_cmd = 1'b0;
    @(posedge clk);
    #3;
    send_m(4'd1, 64'hFFFF_0000_FFFF_0000, 64'h0, 12, 9, 6'd1);
    send_m(4'd2, 64'h0123_4567_89AB_CDEF, 64'h0, 20, 7, 6'd2);
    drive(4'd3, 64'h0, 64'hABCD, 16, 15, 6'd3);
    @(negedge clk);
    chk("bp_ready", 64'(req_ready_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 ready_cmd = 1'b1;
    model(4'd3, 64'h0, 64'hABCD, 16, 15, r, m);
    wait_accept(r, m, 6'd3);
    send_m(4'd7, 64'hDEAD_BEEF_0000_FFFF, 64'h0, 0, 63, 6'd4);
    idle();
    drain();

    // Reset mid-stream with both stages occupied
    @(posedge clk);
    #1 ready_cmd = 1'b0;
    @(posedge clk);
    #3;
    send_m(4'd0, 64'h0, 64'h0, 0, 0, 6'd20);
    send_m(4'd0, 64'h0, 64'h0, 1, 0, 6'd21);
    drive(4'd0, 64'h0, 64'h0, 2, 0, 6'd22);
    #1 rst_i = 1'b1;
    #1;
    chk("rstm_valid", 64'(res_valid_o), 64'd0);
    chk("rstm_res", res_o, 64'd0);
    chk("rstm_mask", mask_o, 64'd0);
    chk("rstm_tag", 64'(tag_o), 64'd0);
    idle();
    sb.delete();
    ready_cmd = 1'b1;
    @(posedge clk);
    #3 rst_i = 1'b0;
    @(posedge clk);
    #1;
    send(4'd3, 64'h0, 64'h3, 30, 1, 6'd23, 64'hC0000000, 64'hC0000000);
    idle();
    @(negedge clk);
    chk("rlat1_valid", 64'(res_valid_o), 64'd0);
    @(negedge clk);
    chk("rlat2_valid", 64'(res_valid_o), 64'd1);
    drain();

    // Random traffic with random output backpressure
    rnd_bp = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 60; i++) begin
      send_m(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 63), $urandom_range(0, 63), 6'(i));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    idle();
    rnd_bp = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
